// File: rtl/uart_dev_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit positions,
// FSM encodings and the divisor clamp.
package uart_dev_pkg;

   localparam logic [2:0] REG_TXDATA  = 3'd0;
   localparam logic [2:0] REG_RXDATA  = 3'd1;
   localparam logic [2:0] REG_CTRL    = 3'd2;
   localparam logic [2:0] REG_STATUS  = 3'd3;
   localparam logic [2:0] REG_DIVISOR = 3'd4;

   localparam int ST_RX_VALID   = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_TX_FULL    = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_FRAME_ERR  = 4;
   localparam int ST_COUNT_LSB  = 8;

   localparam logic [15:0] MIN_DIV = 16'd2;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // A divisor of 0 or 1 would leave no room for the half-bit RX wait.
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the TX serializer; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_dev.sv
// Memory-mapped UART: register window with combinational read, FIFO-fed TX serializer,
// RX deserializer with a single-byte holding register, level IRQ.
module uart_dev
   import uart_dev_pkg::*;
#(
   parameter int          TX_DEPTH    = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   input  logic        uart_rxd,
   output logic        uart_txd
);
   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic [2:0]    reg_sel;
   logic          wr_txdata, wr_rxdata, wr_ctrl, wr_status, wr_div;
   logic [1:0]    ctrl;
   logic [15:0]   divisor;
   logic          fifo_full, fifo_empty, tx_pop, tx_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [7:0]    rx_data;
   logic          rx_valid, rx_overrun, frame_err, rx_load, rx_ferr;
   logic [31:0]   status;
   logic          unused_bits;

   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt, tx_cnt_next, tx_div, tx_div_next;
   logic [2:0]  tx_bit, tx_bit_next;
   logic [7:0]  tx_shift, tx_shift_next;
   logic        tx_tick, txd_next;

   rx_state_t   rx_state, rx_next;
   logic [15:0] rx_cnt, rx_cnt_next, rx_div, rx_div_next;
   logic [2:0]  rx_bit, rx_bit_next;
   logic [7:0]  rx_shift, rx_shift_next;
   logic        rx_meta, rx_s, rx_prev, rx_tick, rx_half;

   assign reg_sel     = Addr[2:0];
   assign wr_txdata   = WE && (reg_sel == REG_TXDATA);
   assign wr_rxdata   = WE && (reg_sel == REG_RXDATA);
   assign wr_ctrl     = WE && (reg_sel == REG_CTRL);
   assign wr_status   = WE && (reg_sel == REG_STATUS);
   assign wr_div      = WE && (reg_sel == REG_DIVISOR);
   assign unused_bits = ^{Addr[29:3], Din[31:16]};

   uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (tx_pop),
      .din   (Din[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl    <= '0;
         divisor <= DEFAULT_DIV;
      end else begin
         if (wr_ctrl) ctrl <= Din[1:0];
         if (wr_div)  divisor <= clamp_div(Din[15:0]);
      end
   end

   // Each TX frame runs on the divisor captured at its pop, so DIVISOR writes wait for the next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DEFAULT_DIV;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_txd <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_next;
         tx_div   <= tx_div_next;
         tx_bit   <= tx_bit_next;
         tx_shift <= tx_shift_next;
         uart_txd <= txd_next;
      end
   end

   assign tx_tick = (tx_cnt == tx_div - 16'd1);

   always_comb begin
      tx_next       = tx_state;
      tx_cnt_next   = tx_cnt + 16'd1;
      tx_div_next   = tx_div;
      tx_bit_next   = tx_bit;
      tx_shift_next = tx_shift;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_next = '0;
            if (!fifo_empty) begin
               tx_next       = TX_START;
               tx_div_next   = divisor;
               tx_shift_next = fifo_dout;
            end
         end
         TX_START: if (tx_tick) begin
            tx_next     = TX_DATA;
            tx_cnt_next = '0;
            tx_bit_next = '0;
         end
         TX_DATA: if (tx_tick) begin
            tx_cnt_next   = '0;
            tx_shift_next = {1'b0, tx_shift[7:1]};
            tx_bit_next   = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_next = TX_STOP;
         end
         TX_STOP: if (tx_tick) begin
            tx_cnt_next = '0;
            if (!fifo_empty) begin
               tx_next       = TX_START;
               tx_div_next   = divisor;
               tx_shift_next = fifo_dout;
            end else begin
               tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // txd is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      tx_pop = 1'b0;
      if ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_tick)) tx_pop = !fifo_empty;
      case (tx_next)
         TX_START: txd_next = 1'b0;
         TX_DATA:  txd_next = tx_shift_next[0];
         default:  txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DEFAULT_DIV;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta  <= uart_rxd;
         rx_s     <= rx_meta;
         rx_prev  <= rx_s;
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_next;
         rx_div   <= rx_div_next;
         rx_bit   <= rx_bit_next;
         rx_shift <= rx_shift_next;
      end
   end

   assign rx_half = (rx_cnt == ({1'b0, rx_div[15:1]} - 16'd1));
   assign rx_tick = (rx_cnt == rx_div - 16'd1);

   always_comb begin
      rx_next       = rx_state;
      rx_cnt_next   = rx_cnt + 16'd1;
      rx_div_next   = rx_div;
      rx_bit_next   = rx_bit;
      rx_shift_next = rx_shift;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_next = '0;
            if (rx_prev && !rx_s) begin
               rx_next     = RX_START;
               rx_div_next = divisor;
            end
         end
         RX_START: if (rx_half) begin
            rx_cnt_next = '0;
            rx_bit_next = '0;
            rx_next     = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_tick) begin
            rx_cnt_next   = '0;
            rx_shift_next = {rx_s, rx_shift[7:1]};
            rx_bit_next   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_next = RX_STOP;
         end
         RX_STOP: if (rx_tick) begin
            rx_cnt_next = '0;
            rx_next     = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_load = 1'b0;
      rx_ferr = 1'b0;
      if ((rx_state == RX_STOP) && rx_tick) begin
         rx_load = rx_s;
         rx_ferr = !rx_s;
      end
   end

   // A completing byte beats a same-cycle RXDATA clear; the clear then leaves overrun alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (rx_load) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            if (!wr_rxdata) rx_overrun <= rx_overrun | rx_valid;
         end else if (wr_rxdata) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
         if (rx_ferr) frame_err <= 1'b1;
         else if (wr_status && Din[ST_FRAME_ERR]) frame_err <= 1'b0;
      end
   end

   assign tx_empty = fifo_empty && (tx_state == TX_IDLE);
   assign IRQ      = (ctrl[0] && rx_valid) || (ctrl[1] && tx_empty);

   always_comb begin
      status                       = '0;
      status[ST_RX_VALID]          = rx_valid;
      status[ST_TX_EMPTY]          = tx_empty;
      status[ST_TX_FULL]           = fifo_full;
      status[ST_RX_OVERRUN]        = rx_overrun;
      status[ST_FRAME_ERR]         = frame_err;
      status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
      case (reg_sel)
         REG_RXDATA:  Dout = {24'b0, rx_data};
         REG_CTRL:    Dout = {30'b0, ctrl};
         REG_STATUS:  Dout = status;
         REG_DIVISOR: Dout = {16'b0, divisor};
         default:     Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_dev.sv
// Directed self-checking bench for uart_dev: register map, TX framing and back-to-back
// streaming, RX reception/overrun/framing error, glitch rejection and mid-frame reset.
module tb_uart_dev;
   import uart_dev_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [29:0] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          start_cyc;
   logic [31:0] rd;
   logic [7:0]  b;
   logic        found;

   uart_dev #(.TX_DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
      .clk      (clk),
      .reset    (reset),
      .Addr     (Addr),
      .WE       (WE),
      .Din      (Din),
      .Dout     (Dout),
      .IRQ      (IRQ),
      .uart_rxd (uart_rxd),
      .uart_txd (uart_txd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic busWrite(input logic [2:0] off, input logic [31:0] data);
      @(negedge clk);
      Addr = {27'b0, off};
      Din  = data;
      WE   = 1'b1;
      @(negedge clk);
      WE   = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] off, output logic [31:0] data);
      @(negedge clk);
      Addr = {27'b0, off};
      #1;
      data = Dout;
   endtask

   task automatic waitStart(input int limit, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (uart_txd === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Samples one DIV=4 frame; first_wait negedges bring the sample point into the start bit.
   task automatic sampleFrame(input int first_wait, output logic [7:0] data);
      repeat (first_wait) @(negedge clk);
      checkOutput("tx_start_bit", {31'b0, uart_txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         data[i] = uart_txd;
      end
      repeat (4) @(negedge clk);
      checkOutput("tx_stop_bit", {31'b0, uart_txd}, 32'd1);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stop);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = data[i];
         repeat (4) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      $display("[TB] start");
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      Addr = {27'b0, REG_STATUS};
      #1 checkOutput("reset_status", Dout, 32'h0000_0002);
      Addr = {27'b0, REG_DIVISOR};
      #1 checkOutput("reset_divisor", Dout, 32'd16);
      checkOutput("reset_txd", {31'b0, uart_txd}, 32'd1);
      checkOutput("reset_irq", {31'b0, IRQ}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      busWrite(REG_DIVISOR, 32'd4);
      busRead(REG_DIVISOR, rd);
      checkOutput("divisor_4", rd, 32'd4);
      busRead(REG_CTRL, rd);
      checkOutput("ctrl_reset", rd, 32'd0);
      busWrite(3'd5, 32'hFFFF_FFFF);
      busRead(3'd5, rd);
      checkOutput("unmapped_read", rd, 32'd0);

      // Single byte 0xA5
      busWrite(REG_TXDATA, 32'h0000_00A5);
      waitStart(2, found);
      checkOutput("tx_start_latency", {31'b0, found}, 32'd1);
      sampleFrame(2, b);
      checkOutput("tx_byte_a5", {24'b0, b}, 32'h0000_00A5);
      busRead(REG_STATUS, rd);
      checkOutput("tx_busy_in_stop", rd, 32'h0000_0000);
      busRead(REG_STATUS, rd);
      checkOutput("tx_empty_after_stop", rd, 32'h0000_0002);

      // Five back-to-back writes; the first pop frees a slot so 0x05 fits
      @(negedge clk);
      Addr = {27'b0, REG_TXDATA};
      WE   = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         Din = i;
         @(negedge clk);
      end
      WE   = 1'b0;
      Addr = {27'b0, REG_STATUS};
      #1 checkOutput("tx_full_status", Dout, 32'h0000_0404);
      start_cyc = cyc - 3;
      sampleFrame(0, b);
      checkOutput("tx_stream_byte1", {24'b0, b}, 32'h0000_0001);
      for (int k = 2; k <= 5; k++) begin
         waitStart(4, found);
         checkOutput("tx_stream_start", {31'b0, found}, 32'd1);
         checkOutput("tx_stream_gap", 32'(cyc - start_cyc), 32'd40);
         start_cyc = cyc;
         sampleFrame(2, b);
         checkOutput("tx_stream_byte", {24'b0, b}, 32'(k));
      end
      repeat (2) @(negedge clk);
      busRead(REG_STATUS, rd);
      checkOutput("tx_stream_drained", rd, 32'h0000_0002);

      // RX byte, interrupt, clear
      applyStimulus(8'h3C, 1'b1);
      busRead(REG_STATUS, rd);
      checkOutput("rx_valid_status", rd, 32'h0000_0003);
      busRead(REG_RXDATA, rd);
      checkOutput("rx_data_3c", rd, 32'h0000_003C);
      checkOutput("irq_masked", {31'b0, IRQ}, 32'd0);
      busWrite(REG_CTRL, 32'd1);
      checkOutput("irq_rx", {31'b0, IRQ}, 32'd1);
      busWrite(REG_RXDATA, 32'd0);
      checkOutput("irq_rx_cleared", {31'b0, IRQ}, 32'd0);
      busRead(REG_STATUS, rd);
      checkOutput("rx_valid_cleared", rd, 32'h0000_0002);
      busWrite(REG_CTRL, 32'd2);
      checkOutput("irq_tx_empty", {31'b0, IRQ}, 32'd1);
      busWrite(REG_CTRL, 32'd0);

      // Overrun, then framing error
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      busRead(REG_RXDATA, rd);
      checkOutput("rx_overrun_data", rd, 32'h0000_0022);
      busRead(REG_STATUS, rd);
      checkOutput("rx_overrun_status", rd, 32'h0000_000B);
      busWrite(REG_RXDATA, 32'd0);
      applyStimulus(8'h5A, 1'b0);
      busRead(REG_STATUS, rd);
      checkOutput("frame_err_status", rd, 32'h0000_0012);
      busRead(REG_RXDATA, rd);
      checkOutput("frame_err_data_kept", rd, 32'h0000_0022);
      busWrite(REG_STATUS, 32'h0000_0010);
      busRead(REG_STATUS, rd);
      checkOutput("frame_err_cleared", rd, 32'h0000_0002);

      // Glitch rejection and divisor clamp
      @(negedge clk);
      uart_rxd = 1'b0;
      @(negedge clk);
      uart_rxd = 1'b1;
      repeat (20) @(negedge clk);
      busRead(REG_STATUS, rd);
      checkOutput("glitch_no_byte", rd, 32'h0000_0002);
      busWrite(REG_DIVISOR, 32'd1);
      busRead(REG_DIVISOR, rd);
      checkOutput("divisor_clamp", rd, 32'd2);

      // Overfill with long frames, then reset mid-frame
      busWrite(REG_DIVISOR, 32'd100);
      @(negedge clk);
      Addr = {27'b0, REG_TXDATA};
      WE   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         Din = 32'h10 + i;
         @(negedge clk);
      end
      WE   = 1'b0;
      Addr = {27'b0, REG_STATUS};
      #1 checkOutput("tx_full_drop", Dout, 32'h0000_0404);
      checkOutput("txd_mid_start", {31'b0, uart_txd}, 32'd0);
      reset = 1'b0;
      #1 checkOutput("reset_mid_tx_txd", {31'b0, uart_txd}, 32'd1);
      checkOutput("reset_mid_tx_status", Dout, 32'h0000_0002);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
